// File: rtl/lot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lot_pkg
// Purpose  : Shared types and constants for the parking-lot gate counter:
//            passage FSM state encoding and photo-sensor {a,b} patterns.
// Revision : 1.0 - initial release
// ============================================================================
package lot_pkg;

  // Passage FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IN1  = 3'd1,
    IN2  = 3'd2,
    IN3  = 3'd3,
    OUT1 = 3'd4,
    OUT2 = 3'd5,
    OUT3 = 3'd6
  } gate_state_t;

  // Sensor patterns written {a,b}; a is the outer beam, b the inner beam
  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] A_ONLY = 2'b10;
  localparam logic [1:0] B_ONLY = 2'b01;
  localparam logic [1:0] BOTH   = 2'b11;

endpackage : lot_pkg
`default_nettype wire

// File: rtl/gate_fsm.sv
`default_nettype none
// ============================================================================
// Module   : gate_fsm
// Purpose  : Tracks one vehicle passage through a two-beam gate. Emits a
//            single-cycle strobe when an entry or exit completes, or when an
//            illegal sensor transition is seen. Strobes are decoded from the
//            current state and sampled pattern so the enclosing counter can
//            update on the very edge that samples the completing pattern.
// Revision : 1.0 - initial release
// ============================================================================
module gate_fsm
  import lot_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic entry_evt,
  output logic exit_evt,
  output logic seq_err
);

  gate_state_t r_state;
  gate_state_t w_next;
  logic [1:0]  w_pat;

  assign w_pat = {a, b};

  // Next-state and event decode; holding a pattern keeps the state
  always_comb begin
    w_next    = r_state;
    entry_evt = 1'b0;
    exit_evt  = 1'b0;
    seq_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pat == A_ONLY)      w_next = IN1;
        else if (w_pat == B_ONLY) w_next = OUT1;
        else if (w_pat == BOTH)   seq_err = 1'b1;
      end
      IN1: begin
        if (w_pat == BOTH)        w_next = IN2;
        else if (w_pat == NONE)   w_next = IDLE;
        else if (w_pat == B_ONLY) begin w_next = IDLE; seq_err = 1'b1; end
      end
      IN2: begin
        if (w_pat == B_ONLY)      w_next = IN3;
        else if (w_pat == A_ONLY) w_next = IN1;
        else if (w_pat == NONE)   w_next = IDLE;
      end
      IN3: begin
        if (w_pat == NONE)        begin w_next = IDLE; entry_evt = 1'b1; end
        else if (w_pat == BOTH)   w_next = IN2;
        else if (w_pat == A_ONLY) begin w_next = IDLE; seq_err = 1'b1; end
      end
      OUT1: begin
        if (w_pat == BOTH)        w_next = OUT2;
        else if (w_pat == NONE)   w_next = IDLE;
        else if (w_pat == A_ONLY) begin w_next = IDLE; seq_err = 1'b1; end
      end
      OUT2: begin
        if (w_pat == A_ONLY)      w_next = OUT3;
        else if (w_pat == B_ONLY) w_next = OUT1;
        else if (w_pat == NONE)   w_next = IDLE;
      end
      OUT3: begin
        if (w_pat == NONE)        begin w_next = IDLE; exit_evt = 1'b1; end
        else if (w_pat == BOTH)   w_next = OUT2;
        else if (w_pat == B_ONLY) begin w_next = IDLE; seq_err = 1'b1; end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; reset discards any partial passage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

endmodule : gate_fsm
`default_nettype wire

// File: rtl/lot_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : lot_occupancy_counter
// Purpose  : Parking-lot occupancy counter. Two photo beams feed a passage
//            FSM; completed entries/exits drive a saturating counter with
//            sticky overflow/underflow flags and one-cycle event pulses.
// Config   : LOT_COUNTER_SYNC_EN - when defined, each sensor passes through
//            a two-flop synchroniser (adds two cycles of event latency).
// Revision : 1.0 - initial release
// ============================================================================
module lot_occupancy_counter
  import lot_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sens_a,
  input  logic             sens_b,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             seq_err,
  output logic             ovf,
  output logic             unf
);

  localparam longint     c_max_count = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] c_cap = WIDTH'(CAPACITY);

  generate
    if (CAPACITY < 1 || longint'(CAPACITY) > c_max_count) begin : g_cap_check
      $error("lot_occupancy_counter: CAPACITY must be in 1 .. 2**WIDTH-1");
    end
  endgenerate

  logic w_a;
  logic w_b;

`ifdef LOT_COUNTER_SYNC_EN
  logic [1:0] r_meta;
  logic [1:0] r_sync;

  // Two-flop synchroniser for the asynchronous beam sensors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {sens_a, sens_b};
      r_sync <= r_meta;
    end
  end

  assign w_a = r_sync[1];
  assign w_b = r_sync[0];
`else
  assign w_a = sens_a;
  assign w_b = sens_b;
`endif

  logic w_entry;
  logic w_exit;
  logic w_err;

  gate_fsm u_gate_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (w_a),
    .b         (w_b),
    .entry_evt (w_entry),
    .exit_evt  (w_exit),
    .seq_err   (w_err)
  );

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_entry_pulse;
  logic             r_exit_pulse;
  logic             r_seq_err;

  // Saturating occupancy counter; clr overrides any same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_entry) begin
      if (r_count < c_cap) r_count <= r_count + 1'b1;
      else                 r_ovf   <= 1'b1;
    end else if (w_exit) begin
      if (r_count != '0)   r_count <= r_count - 1'b1;
      else                 r_unf   <= 1'b1;
    end
  end

  // Event pulses registered alongside the count so both change together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_entry_pulse <= w_entry;
      r_exit_pulse  <= w_exit;
      r_seq_err     <= w_err;
    end
  end

  assign count       = r_count;
  assign full        = (r_count == c_cap);
  assign empty       = (r_count == '0);
  assign entry_pulse = r_entry_pulse;
  assign exit_pulse  = r_exit_pulse;
  assign seq_err     = r_seq_err;
  assign ovf         = r_ovf;
  assign unf         = r_unf;

endmodule : lot_occupancy_counter
`default_nettype wire

// File: tb/tb_lot_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lot_occupancy_counter
// Purpose  : Self-checking bench for lot_occupancy_counter (CAPACITY = 4).
//            A path-position model of the gate predicts every output each
//            cycle; directed passages add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lot_occupancy_counter;

  localparam int WIDTH = 8;
  localparam int CAP   = 4;
`ifdef LOT_COUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic clr    = 1'b0;

  logic [WIDTH-1:0] count;
  logic full, empty, entry_pulse, exit_pulse, seq_err, ovf, unf;

  always #5 clk = ~clk;

  lot_occupancy_counter #(.WIDTH(WIDTH), .CAPACITY(CAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sens_a      (sens_a),
    .sens_b      (sens_b),
    .clr         (clr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .seq_err     (seq_err),
    .ovf         (ovf),
    .unf         (unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A passage is a walk along a 4-step pattern path (00, first, both, last).
  // pos is how far along the path the vehicle is; dir +1 = entering, -1 = exiting.
  function automatic logic [1:0] path_pat(input int dir, input int pos);
    logic [1:0] p;
    p = 2'b00;
    if (dir > 0) begin
      if (pos == 1) p = 2'b10; else if (pos == 2) p = 2'b11; else if (pos == 3) p = 2'b01;
    end else begin
      if (pos == 1) p = 2'b01; else if (pos == 2) p = 2'b11; else if (pos == 3) p = 2'b10;
    end
    return p;
  endfunction

  int         m_dir = 0, m_pos = 0, m_count = 0;
  bit         m_ovf = 0, m_unf = 0, m_ent = 0, m_ext = 0, m_err = 0;
  logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00;
  int         n_dir, n_pos;
  bit         n_ent, n_ext, n_err;
  logic [1:0] m_pat;

  always @* begin
`ifdef LOT_COUNTER_SYNC_EN
    m_pat = m_s2;
`else
    m_pat = {sens_a, sens_b};
`endif
    n_dir = m_dir; n_pos = m_pos; n_ent = 0; n_ext = 0; n_err = 0;
    if (m_pos == 0) begin
      if (m_pat == 2'b10)      begin n_dir = 1;  n_pos = 1; end
      else if (m_pat == 2'b01) begin n_dir = -1; n_pos = 1; end
      else if (m_pat == 2'b11) n_err = 1;
    end else if (m_pat == path_pat(m_dir, m_pos)) begin
      n_pos = m_pos;
    end else if (m_pos < 3 && m_pat == path_pat(m_dir, m_pos + 1)) begin
      n_pos = m_pos + 1;
    end else if (m_pat == path_pat(m_dir, m_pos - 1)) begin
      n_pos = m_pos - 1;
    end else if (m_pat == 2'b00) begin
      n_pos = 0;
      if (m_pos == 3) begin
        if (m_dir > 0) n_ent = 1; else n_ext = 1;
      end
    end else begin
      n_pos = 0; n_err = 1;
    end
    if (n_pos == 0) n_dir = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dir <= 0; m_pos <= 0; m_count <= 0;
      m_ovf <= 0; m_unf <= 0; m_ent <= 0; m_ext <= 0; m_err <= 0;
      m_s1 <= 2'b00; m_s2 <= 2'b00;
    end else begin
      m_s1 <= {sens_a, sens_b};
      m_s2 <= m_s1;
      m_dir <= n_dir; m_pos <= n_pos;
      m_ent <= n_ent; m_ext <= n_ext; m_err <= n_err;
      if (clr) begin
        m_count <= 0; m_ovf <= 0; m_unf <= 0;
      end else if (n_ent) begin
        if (m_count < CAP) m_count <= m_count + 1; else m_ovf <= 1;
      end else if (n_ext) begin
        if (m_count > 0) m_count <= m_count - 1; else m_unf <= 1;
      end
    end
  end

  // Every-cycle comparison, away from the rising edge
  always @(negedge clk) begin
    chk("count",       int'(count),       m_count);
    chk("full",        int'(full),        int'(m_count == CAP));
    chk("empty",       int'(empty),       int'(m_count == 0));
    chk("entry_pulse", int'(entry_pulse), int'(m_ent));
    chk("exit_pulse",  int'(exit_pulse),  int'(m_ext));
    chk("seq_err",     int'(seq_err),     int'(m_err));
    chk("ovf",         int'(ovf),         int'(m_ovf));
    chk("unf",         int'(unf),         int'(m_unf));
    chk("pulse_excl",  int'(entry_pulse & exit_pulse), 0);
  end

  // ---------------- stimulus ----------------
  // Present a pattern, let one rising edge sample it, return just after.
  task automatic drive(input logic [1:0] p);
    {sens_a, sens_b} = p;
    @(posedge clk);
    #2;
  endtask

  // Idle cycles covering the synchroniser delay, if present
  task automatic settle();
    repeat (LAT) drive(2'b00);
  endtask

  task automatic entry_pass();
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00); settle();
  endtask

  task automatic exit_pass();
    drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00); settle();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    rst_n = 1'b1;

    // Single entry: 10,11,01,00
    entry_pass();
    chk("entry1_pulse", int'(entry_pulse), 1);
    chk("entry1_count", int'(count), 1);
    chk("entry1_empty", int'(empty), 0);
    drive(2'b00);
    chk("entry1_once", int'(entry_pulse), 0);

    // Up to 3, then one exit: 3 -> 2
    entry_pass(); entry_pass();
    chk("count3", int'(count), 3);
    exit_pass();
    chk("exit_pulse", int'(exit_pulse), 1);
    chk("exit_count", int'(count), 2);

    // Saturate at capacity 4; third entry overflows
    entry_pass(); entry_pass(); entry_pass();
    chk("sat_count", int'(count), 4);
    chk("sat_full",  int'(full), 1);
    chk("sat_ovf",   int'(ovf), 1);
    chk("sat_pulse", int'(entry_pulse), 1);

    // Clear
    clr = 1'b1; drive(2'b00); clr = 1'b0;
    chk("clr_count", int'(count), 0);
    chk("clr_ovf",   int'(ovf), 0);

    // Exit while empty
    exit_pass();
    chk("unf_count", int'(count), 0);
    chk("unf_flag",  int'(unf), 1);
    chk("unf_pulse", int'(exit_pulse), 1);

    // Back-out after one entry: count stays 1
    entry_pass();
    drive(2'b10); drive(2'b11); drive(2'b10); drive(2'b00); settle();
    chk("backout_pulse", int'(entry_pulse), 0);
    chk("backout_count", int'(count), 1);

    // 00 -> 11 from idle is illegal, one-cycle seq_err
    drive(2'b11); settle();
    chk("seqerr_hi", int'(seq_err), 1);
    drive(2'b00);
    chk("seqerr_lo", int'(seq_err), 0);

    // clr coinciding with completing entry: clr wins, pulse still emitted
    drive(2'b10); drive(2'b11); drive(2'b01);
    if (LAT == 0) clr = 1'b1;
    drive(2'b00);
    clr = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (i == LAT - 1) clr = 1'b1;
      drive(2'b00);
      clr = 1'b0;
    end
    chk("clrevt_pulse", int'(entry_pulse), 1);
    chk("clrevt_count", int'(count), 0);
    chk("clrevt_unf",   int'(unf), 0);

    // Build count to 1, then reset while in IN2: partial passage discarded
    entry_pass();
    drive(2'b10); drive(2'b11);
    repeat (LAT) drive(2'b11);
    rst_n = 1'b0;
    drive(2'b00);
    chk("midrst_count", int'(count), 0);
    rst_n = 1'b1;
    repeat (LAT + 1) drive(2'b00);
    chk("midrst_pulse", int'(entry_pulse), 0);
    drive(2'b00);
    chk("midrst_count2", int'(count), 0);
    chk("midrst_empty",  int'(empty), 1);

    drive(2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the run never needs anywhere near this long
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lot_occupancy_counter
`default_nettype wire
